// File: rtl/arith_defs_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arith_defs
// Description : Shared definitions for the serial arithmetic units: the
//               sequencer state encoding and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_defs;

  // State encodings for the start/busy/done sequencer
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Smallest r such that 2**r >= value; sizes a counter that must reach
  // value-1. Returns at least 1 so a counter is never zero bits wide.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage : arith_defs
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Combinational 1-bit full subtractor, d = x - y - bin with
//               borrow-out. Subtract-direction twin of the 1-bit full adder.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit is the parity of all three inputs; a borrow is produced
  // when y exceeds x, or when x equals y and a borrow is already pending.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial LSB-first subtractor, diff = a - b - bin over
//               WIDTH cycles with a single 1-bit cell and a borrow flop.
//               start/busy/done handshake; results held until the next
//               operation completes.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import arith_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Sequencer
  state_t state_q, state_d;

  // Datapath working registers
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;

  // Result registers, visible at the ports
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  // Cell outputs
  logic cell_d;
  logic cell_bout;

  full_subtractor u_cell (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state and datapath update; every register holds by default
  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // One bit per cycle; the difference fills from the MSB end so the
        // first (LSB) result bit lands at position 0 after WIDTH shifts.
        a_sr_d    = a_sr_q >> 1;
        b_sr_d    = b_sr_q >> 1;
        diff_sr_d = {cell_d, diff_sr_q[WIDTH-1:1]};
        borrow_d  = cell_bout;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Publish the finished result. Signed overflow is only possible
        // when the operand signs differ and the result sign disagrees with
        // the minuend; the borrow-in never creates overflow on its own.
        done_d = 1'b1;
        diff_d = diff_sr_q;
        bout_d = borrow_q;
        zero_d = (diff_sr_q == '0);
        ovf_d  = (a_msb_q != b_msb_q) && (diff_sr_q[WIDTH-1] != a_msb_q);
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      borrow_q  <= borrow_d;
      cnt_q     <= cnt_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
    end
  end

  // Result registers and done pulse with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end

  // Port drive
  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    diff = diff_q;
    bout = bout_q;
    ovf  = ovf_q;
    zero = zero_q;
  end

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=8) with a
//               protocol model and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         zero;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic: unsigned 9-bit subtraction for diff/borrow and
  // an integer signed subtraction for overflow.
  function automatic exp_t ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin);
    exp_t e;
    logic [W:0] full;
    int sres;
    full   = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
    sres   = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.ovf  = (sres > 127) || (sres < -128);
    e.zero = (full[W-1:0] == '0);
    return e;
  endfunction

  // Protocol model: phase 0 idle, 1..W running, W+1 the publish cycle
  int   phase = 0;
  logic exp_done = 1'b0;
  logic active = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      phase    = 0;
      exp_done = 1'b0;
      exp_q.delete();
    end else begin
      exp_done = (phase == W + 1);
      if (start && (phase == 0 || phase == W + 1)) begin
        exp_q.push_back(ref_sub(a, b, bin));
        phase = 1;
      end else if (phase == W + 1) begin
        phase = 0;
      end else if (phase != 0) begin
        phase = phase + 1;
      end
    end
  end

  // Output monitor: handshake timing, result scoreboard, hold-stability
  logic [W+2:0] last_res = '0;

  always @(negedge clk) begin
    if (rst) begin
      last_res = '0;
    end else if (active) begin
      check_eq("busy", busy, (phase >= 1 && phase <= W));
      check_eq("done", done, exp_done);
      if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("diff", diff, e.diff);
          check_eq("bout", bout, e.bout);
          check_eq("ovf", ovf, e.ovf);
          check_eq("zero", zero, e.zero);
        end
        last_res = {diff, bout, ovf, zero};
      end else begin
        check_eq("hold", {diff, bout, ovf, zero}, last_res);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb;
    bin   = tbin;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {busy, done, diff, bout, ovf, zero}, '0);
    rst    = 1'b0;
    active = 1'b1;

    // Directed operations
    do_op(8'h50, 8'h20, 1'b0);
    do_op(8'h00, 8'h01, 1'b0);
    do_op(8'h80, 8'h01, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0);
    do_op(8'h05, 8'h04, 1'b1);
    do_op(8'h00, 8'h00, 1'b1);
    do_op(8'h80, 8'h00, 1'b1);

    // start held high with operands changing every cycle
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      bin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    start = 1'b1;
    a     = 8'h50;
    b     = 8'h20;
    bin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("abort_outputs", {busy, done, diff, bout, ovf, zero}, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Normal operation after the abort
    do_op(8'h50, 8'h20, 1'b0);
    do_op(8'hC3, 8'h5A, 1'b1);

    repeat (4) @(negedge clk);
    check_eq("results_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_subtractor
`default_nettype wire
